// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder slice.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_WAIT = 3'd2,
    IO_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus between a master (CPU) and the responder.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);

endinterface

// File: rtl/wait_counter.sv
// Loadable 8-bit down counter; tc marks the last cycle of a loaded interval.
module wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic       tc
);

  logic [7:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  // A count of N loaded before the interval yields tc on its Nth enabled cycle.
  assign tc = (count_reg == 8'd1);

endmodule

// File: rtl/mem_responder.sv
// Routes CPU requests to block RAM or memory-mapped I/O and returns a one-cycle ack.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEF),
  parameter int                BRAM_LAT   = 1,
  parameter int                IO_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  mem_responder_if.slave    bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack
);

  state_t            state_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              cnt_load;
  logic [7:0]        cnt_value;
  logic              cnt_enable;
  logic              cnt_tc;

  // One counter times both the RAM latency and the I/O timeout; it is loaded
  // on the edge that enters the corresponding wait state.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_value  = 8'(BRAM_LAT);
    cnt_enable = (state_reg == RAM_WAIT) || (state_reg == IO_WAIT);
    if (state_reg == IDLE && bus.req && bus.addr >= IO_BASE) begin
      cnt_load  = 1'b1;
      cnt_value = 8'(IO_TIMEOUT);
    end else if (state_reg == RAM_ACC && !we_reg) begin
      cnt_load  = 1'b1;
    end
  end

  wait_counter u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (cnt_enable),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            we_reg    <= bus.we;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
            bus.busy  <= 1'b1;
            if (bus.addr < IO_BASE) begin
              state_reg <= RAM_ACC;
              ram_en    <= 1'b1;
              ram_we    <= bus.we;
            end else begin
              state_reg <= IO_WAIT;
              io_req    <= 1'b1;
              io_we     <= bus.we;
            end
          end
        end
        RAM_ACC: begin
          if (we_reg) begin
            state_reg <= RESP;
            bus.ack   <= 1'b1;
          end else begin
            state_reg <= RAM_WAIT;
          end
        end
        RAM_WAIT: begin
          if (cnt_tc) begin
            bus.rdata <= ram_rdata;
            state_reg <= RESP;
            bus.ack   <= 1'b1;
          end
        end
        IO_WAIT: begin
          // io_ack takes priority over a timeout expiring on the same cycle.
          if (io_ack) begin
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            if (!we_reg) bus.rdata <= io_rdata;
            state_reg <= RESP;
            bus.ack   <= 1'b1;
          end else if (cnt_tc) begin
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            if (!we_reg) bus.rdata <= '1;
            state_reg <= RESP;
            bus.ack   <= 1'b1;
            bus.err   <= 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          bus.busy  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign io_addr   = addr_reg[7:0];
  assign io_wdata  = wdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed-vector bench for mem_responder with a 1-cycle BRAM model and a scripted I/O target.
module tb_mem_responder;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          io_req, io_we;
  logic [7:0]    io_addr;
  logic [DW-1:0] io_wdata, io_rdata;
  logic          io_ack;

  int checks;
  int failures;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block RAM model with one cycle of read latency plus a bench preload port.
  logic [DW-1:0] mem [0:1023];
  logic          pre_we;
  logic [9:0]    pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (ram_en) begin
      if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[9:0]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({bus.ack, bus.err, bus.busy, ram_en, ram_we, io_req, io_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {bus.ack, bus.err, bus.busy, ram_en, ram_we, io_req, io_we});
    end
    checks++;
    if (bus.rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata: got %h required 0000", bus.rdata);
    end
    #5;
    reset = 1'b0;
    tick();
    $display("txn reset released busy=%b", bus.busy);
  endtask

  task automatic test_ram_read();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010; bus.wdata = 16'h0000;
    tick();  // cycle 1
    bus.req = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h0010 || io_req !== 1'b0) begin
      failures++;
      $display("FAIL ram_read_c1: got en=%b we=%b addr=%h io_req=%b required 1 0 0010 0",
               ram_en, ram_we, ram_addr, io_req);
    end
    tick();  // cycle 2
    checks++;
    if (bus.ack !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL ram_read_c2: got ack=%b en=%b required 0 0", bus.ack, ram_en);
    end
    tick();  // cycle 3
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== 16'hBEEF || bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL ram_read_ack: got ack=%b rdata=%h err=%b busy=%b required 1 beef 0 1",
               bus.ack, bus.rdata, bus.err, bus.busy);
    end
    tick();  // cycle 4
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL ram_read_c4: got busy=%b ack=%b required 0 0", bus.busy, bus.ack);
    end
    $display("txn ram_read addr=0010 rdata=%h", bus.rdata);
  endtask

  task automatic test_ram_write_read();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h1234;
    tick();  // cycle 1
    bus.req = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 16'h1234 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL ram_write_c1: got en=%b we=%b wdata=%h ack=%b required 1 1 1234 0",
               ram_en, ram_we, ram_wdata, bus.ack);
    end
    tick();  // cycle 2
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL ram_write_ack: got ack=%b rdata=%h required 1 beef", bus.ack, bus.rdata);
    end
    tick();
    checks++;
    if (mem[10'h020] !== 16'h1234 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL ram_write_mem: got mem=%h busy=%b required 1234 0", mem[10'h020], bus.busy);
    end
    $display("txn ram_write addr=0020 wdata=1234");
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0020;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== 16'h1234) begin
      failures++;
      $display("FAIL ram_readback: got ack=%b rdata=%h required 1 1234", bus.ack, bus.rdata);
    end
    tick();
    $display("txn ram_read addr=0020 rdata=%h", bus.rdata);
  endtask

  task automatic test_io_read();
    io_rdata = 16'h00A5;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF05;
    tick();  // cycle 1: io_req rises
    bus.req = 1'b0;
    checks++;
    if (io_req !== 1'b1 || io_addr !== 8'h05 || io_we !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL io_read_c1: got io_req=%b io_addr=%h io_we=%b ram_en=%b required 1 05 0 0",
               io_req, io_addr, io_we, ram_en);
    end
    tick();
    tick();
    tick();  // cycle 4
    checks++;
    if (io_req !== 1'b1 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL io_read_hold: got io_req=%b ack=%b required 1 0", io_req, bus.ack);
    end
    io_ack = 1'b1;
    tick();  // cycle 5
    io_ack = 1'b0;
    checks++;
    if (io_req !== 1'b0 || bus.ack !== 1'b1 || bus.rdata !== 16'h00A5 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL io_read_ack: got io_req=%b ack=%b rdata=%h err=%b required 0 1 00a5 0",
               io_req, bus.ack, bus.rdata, bus.err);
    end
    tick();
    $display("txn io_read addr=ff05 rdata=%h", bus.rdata);
  endtask

  task automatic test_io_timeout();
    int n;
    bit overlap;
    n = 0;
    overlap = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF00;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 40 && io_req; i++) begin
      n++;
      if (ram_en) overlap = 1'b1;
      tick();
    end
    checks++;
    if (n !== 15 || overlap !== 1'b0) begin
      failures++;
      $display("FAIL io_timeout_len: got cycles=%0d overlap=%b required 15 0", n, overlap);
    end
    checks++;
    if (bus.ack !== 1'b1 || bus.err !== 1'b1 || bus.rdata !== 16'hFFFF) begin
      failures++;
      $display("FAIL io_timeout_ack: got ack=%b err=%b rdata=%h required 1 1 ffff",
               bus.ack, bus.err, bus.rdata);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL io_timeout_after: got err=%b busy=%b required 0 0", bus.err, bus.busy);
    end
    $display("txn io_timeout addr=ff00 cycles=%0d rdata=%h", n, bus.rdata);
  endtask

  task automatic test_io_tie();
    io_rdata = 16'h5A5A;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF07;
    tick();  // cycle 1
    bus.req = 1'b0;
    for (int i = 0; i < 14; i++) tick();  // cycle 15: final timeout cycle
    checks++;
    if (io_req !== 1'b1) begin
      failures++;
      $display("FAIL io_tie_hold: got io_req=%b required 1", io_req);
    end
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    checks++;
    if (bus.ack !== 1'b1 || bus.err !== 1'b0 || bus.rdata !== 16'h5A5A || io_req !== 1'b0) begin
      failures++;
      $display("FAIL io_tie_ack: got ack=%b err=%b rdata=%h io_req=%b required 1 0 5a5a 0",
               bus.ack, bus.err, bus.rdata, io_req);
    end
    tick();
    $display("txn io_tie addr=ff07 rdata=%h", bus.rdata);
  endtask

  task automatic test_addr_boundary();
    // Top of the address space is I/O; a store leaves rdata untouched.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'hFFFF; bus.wdata = 16'hCAFE;
    tick();
    bus.req = 1'b0;
    checks++;
    if (io_req !== 1'b1 || io_addr !== 8'hFF || io_we !== 1'b1 || io_wdata !== 16'hCAFE) begin
      failures++;
      $display("FAIL io_write_c1: got io_req=%b io_addr=%h io_we=%b io_wdata=%h required 1 ff 1 cafe",
               io_req, io_addr, io_we, io_wdata);
    end
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== 16'h5A5A || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL io_write_ack: got ack=%b rdata=%h err=%b required 1 5a5a 0",
               bus.ack, bus.rdata, bus.err);
    end
    tick();
    $display("txn io_write addr=ffff wdata=cafe");
    // Just below IO_BASE is RAM.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFEFF;
    tick();
    bus.req = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || io_req !== 1'b0) begin
      failures++;
      $display("FAIL boundary_route: got ram_en=%b io_req=%b required 1 0", ram_en, io_req);
    end
    tick();
    tick();
    checks++;
    if (bus.ack !== 1'b1 || bus.rdata !== 16'h7777) begin
      failures++;
      $display("FAIL boundary_read: got ack=%b rdata=%h required 1 7777", bus.ack, bus.rdata);
    end
    tick();
    $display("txn ram_read addr=feff rdata=%h", bus.rdata);
  endtask

  task automatic test_busy_ignore();
    int acks;
    acks = 0;
    // Stray io_ack while idle must not produce anything.
    io_ack = 1'b1;
    tick();
    tick();
    io_ack = 1'b0;
    checks++;
    if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_io_ack: got ack=%b busy=%b required 0 0", bus.ack, bus.busy);
    end
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    tick();  // cycle 1; keep pulsing req with a different address through RESP
    bus.addr = 16'h0020; bus.we = 1'b1; bus.wdata = 16'hDEAD;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) bus.req = 1'b0;
      if (bus.ack) acks++;
      if (i == 3) begin
        checks++;
        if (bus.rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL busy_rdata: got %h required beef", bus.rdata);
        end
      end
      tick();
    end
    bus.req = 1'b0;
    checks++;
    if (acks !== 1 || mem[10'h020] !== 16'h1234) begin
      failures++;
      $display("FAIL busy_ignore: got acks=%0d mem20=%h required 1 1234", acks, mem[10'h020]);
    end
    $display("txn busy_ignore acks=%0d", acks);
  endtask

  task automatic test_reset_mid_io();
    int acks;
    acks = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF01;
    tick();  // cycle 1
    bus.addr = 16'h0010;  // req still high while busy
    tick();
    tick();
    bus.req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (io_req !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got io_req=%b busy=%b ack=%b required 0 0 0",
               io_req, bus.busy, bus.ack);
    end
    #3;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack || io_req || ram_en) acks++;
    end
    checks++;
    if (acks !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: got activity=%0d busy=%b required 0 0", acks, bus.busy);
    end
    $display("txn reset_mid_io activity=%0d", acks);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    io_ack = 1'b0; io_rdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    preload(10'h010, 16'hBEEF);
    preload(10'h2FF, 16'h7777);
    test_ram_read();
    test_ram_write_read();
    test_io_read();
    test_io_timeout();
    test_io_tie();
    test_addr_boundary();
    test_busy_ignore();
    test_reset_mid_io();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 16: data width.
REQ-002 Parameter ADDR_W, default 16: address width.
REQ-003 Parameter IO_BASE, default 16'hFF00: lowest memory-mapped I/O address; addr >= IO_BASE targets I/O.
REQ-004 Parameter BRAM_LAT, default 1: RAM read latency in cycles after ram_en; legal range 1..4.
REQ-005 Parameter IO_TIMEOUT, default 15: maximum io_req cycles before abort; legal range 1..255.
REQ-006 Port clock, input, 1: single clock; all logic rises on posedge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port req, input, 1: CPU request strobe; sampled only in IDLE.
REQ-009 Port we, input, 1: 1 = store, 0 = load/fetch.
REQ-010 Port addr, input, ADDR_W: request address.
REQ-011 Port wdata, input, DATA_W: store data.
REQ-012 Port ack, output, 1: one-cycle completion pulse.
REQ-013 Port rdata, output, DATA_W: load data; valid with ack and held until the next ack.
REQ-014 Port err, output, 1: pulses with ack when an I/O access times out.
REQ-015 Port busy, output, 1: high whenever state != IDLE.
REQ-016 RAM side, one port each: ram_en (out, 1), ram_we (out, 1), ram_addr (out, ADDR_W), ram_wdata (out, DATA_W), ram_rdata (in, DATA_W).
REQ-017 I/O side, one port each: io_req (out, 1), io_we (out, 1), io_addr (out, 8; addr[7:0]), io_wdata (out, DATA_W), io_rdata (in, DATA_W), io_ack (in, 1).

Function
REQ-018 States SHALL be IDLE, RAM_ACC, RAM_WAIT, IO_WAIT and RESP.
REQ-019 In IDLE with req=1 at cycle N, the block SHALL register we/addr/wdata and enter RAM_ACC if addr < IO_BASE, else IO_WAIT.
REQ-020 RAM_ACC SHALL last one cycle with ram_en=1, ram_we=we and latched addr/wdata driven; a write then goes to RESP, a read goes to RAM_WAIT.
REQ-021 RAM_WAIT SHALL count BRAM_LAT cycles, capture ram_rdata into rdata, then enter RESP; read ack SHALL occur at cycle N+2+BRAM_LAT, write ack at N+2.
REQ-022 In IO_WAIT, io_req SHALL be held high with stable io_we/io_addr/io_wdata until io_ack=1 or IO_TIMEOUT cycles elapse.
REQ-023 io_ack sampled at cycle M SHALL drop io_req at M+1, capture io_rdata into rdata (reads only), and enter RESP, giving ack at M+1.
REQ-024 On timeout, the block SHALL drop io_req, assert err with ack, and, for reads, set rdata=all ones.
REQ-025 If io_ack arrives on the same cycle the timeout count expires, io_ack SHALL win: no err, data captured.
REQ-026 RESP SHALL assert ack (and err if flagged) for exactly one cycle, then return to IDLE; a req in the RESP cycle SHALL be ignored.
REQ-027 req while busy=1 SHALL be ignored, with no latch and no side effect.
REQ-028 On writes, rdata SHALL keep its previous value.
REQ-029 ram_en and io_req SHALL never be high in the same cycle; io_ack outside IO_WAIT SHALL be ignored.
REQ-030 Address compare SHALL be unsigned; addr = 16'hFFFF SHALL map to I/O with io_addr = 8'hFF.

Reset
REQ-031 Reset SHALL force state IDLE, ack=0, err=0, busy=0, rdata=0, ram_en=0, ram_we=0, io_req=0, io_we=0, and all counters to 0, asynchronously.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no ack; io_req SHALL fall without waiting for a clock edge.

Structure
REQ-033 Package mem_pkg SHALL hold the state encoding, DATA_W/ADDR_W defaults and the IO_BASE default.
REQ-034 A sub-module wait_counter (load, enable, terminal-count output, 8 bits) SHALL serve both the BRAM_LAT count and the IO_TIMEOUT count.

Verification
REQ-035 RAM read: memory[0x0010]=0xBEEF, req at cycle 0 with we=0, addr=0x0010 -> ram_en high at cycle 1, ack with rdata=0xBEEF at cycle 3, busy low at cycle 4.
REQ-036 RAM write then read: write 0x1234 to 0x0020 -> ack at cycle 2 and rdata unchanged; a following read of 0x0020 -> rdata=0x1234.
REQ-037 I/O read: addr=0xFF05, io_ack with io_rdata=0x00A5 three cycles after io_req rises -> io_addr=0x05, ack with rdata=0x00A5 the next cycle, err=0.
REQ-038 I/O timeout: addr=0xFF00, io_ack never asserted -> io_req high for exactly 15 cycles, then ack=1, err=1, rdata=0xFFFF.
REQ-039 Tie: io_ack on the final timeout cycle -> ack=1, err=0, io_rdata captured.
REQ-040 Reset during IO_WAIT plus req pulses while busy -> io_req drops asynchronously, no ack, state IDLE; ignored reqs produce no extra ack.
